mul8_issue_ctrl: RTL
====================

# mul8_issue_ctrl

Sequential front/back-end for the 8x8 unsigned combinational Wallace multiplier. Accepts operand requests over a valid/ready handshake, registers the operands onto the multiplier inputs, waits a programmable settle time, then captures and optionally sign-corrects the 16-bit product into a held response register. Sits directly between the ALU issue logic and the multiplier array, and both feeds the array and consumes its output.

## Interface

- MUL_LAT, 1: cycles the multiplier inputs are held before the product is captured; legal range 1..4 (multicycle path budget).

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request this cycle
- req_a  in  8  operand A
- req_b  in  8  operand B
- req_signed  in  1  treat operands as two's complement (see Configuration)
- mul_a  out  8  registered operand to multiplier `a`
- mul_b  out  8  registered operand to multiplier `b`
- mul_result  in  16  unsigned product from multiplier
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_product  out  16  final product (two's complement if signed)
- rsp_ovf8  out  1  product does not fit in 8 bits of the request's type
- busy  out  1  state != IDLE

## Operation

- FSM states: IDLE, CALC, DONE.
- IDLE: req_ready=1. On req_valid: latch mul_a/mul_b, neg flag, signed flag; load cnt=MUL_LAT-1; go CALC.
- Signed request: mul_a=|req_a|, mul_b=|req_b| (8-bit magnitudes, -128 -> 8'h80); neg=req_a[7]^req_b[7]. Unsigned: raw operands, neg=0.
- CALC: req_ready=0. If cnt==0: capture rsp_product = neg ? -mul_result : mul_result (16-bit wrap), compute rsp_ovf8, go DONE; else cnt--.
- rsp_ovf8: unsigned -> rsp_product[15:8]!=0; signed -> rsp_product[15:7] not all equal.
- DONE: rsp_valid=1; req_ready=rsp_ready. rsp_valid&rsp_ready with req_valid: accept new request, go CALC (back-to-back). Without req_valid: go IDLE.
- mul_a/mul_b remain stable from accept until the next accept; never change during CALC.
- rsp_product/rsp_ovf8 stable while rsp_valid=1 and rsp_ready=0.
- Reset (async, any state): state IDLE; all outputs 0 (req_ready returns to 1 on first IDLE cycle after deassertion); in-flight operation discarded, no response.

## Timing

- Accept at rising edge N (req_valid&req_ready). mul_a/mul_b valid after edge N.
- Product captured at edge N+MUL_LAT; rsp_valid high from edge N+MUL_LAT.
- Minimum request-to-response latency: MUL_LAT cycles. Throughput with rsp_ready held high: one result per MUL_LAT+1 cycles.
- Combinational paths: req_ready depends on state and rsp_ready only; no path from req_* to rsp_*.
- Multiplier path constrained as MUL_LAT-cycle multicycle from mul_a/mul_b to rsp_product.

## Configuration

- MUL8_SIGNED_EN defined: req_signed honoured; magnitude conversion, negation and signed ovf8 rule compiled in.
- Undefined: req_signed ignored; all requests unsigned, neg logic absent, rsp_ovf8 uses unsigned rule only.

## Test plan

- MUL_LAT=1, unsigned 200*150 -> mul_a=0xC8, mul_b=0x96; rsp_valid one cycle after accept, rsp_product=0x7530, rsp_ovf8=1.
- MUL8_SIGNED_EN, signed -3*5 -> mul_a=0x03, mul_b=0x05, rsp_product=0xFFF1, ovf8=0; signed -128*-128 -> mul_a=mul_b=0x80, rsp_product=0x4000, ovf8=1.
- MUL_LAT=3, unsigned 15*17 -> rsp_valid exactly 3 cycles after accept, rsp_product=0x00FF, ovf8=0; busy=1 throughout, req_ready=0 in CALC.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_product/ovf8 unchanged, req_ready=0; then rsp_ready=1 with req_valid=1 (2*3) -> same-cycle accept, next rsp_product=0x0006.
- Reset asserted mid-CALC -> all outputs 0 immediately, no rsp_valid after release; next request 1*1 returns 0x0001.
- MUL8_SIGNED_EN undefined, req_signed=1, 0xFF*0xFF -> rsp_product=0xFE01, ovf8=1.

Source files
------------

// File: rtl/mul8_issue_ctrl.sv
// mul8_issue_ctrl: valid/ready front/back-end for the 8x8 combinational multiplier.
// Registers the operands onto the array, holds them MUL_LAT cycles, then captures
// the product into a response register that stays put until the consumer takes it.
// Optional feature: define MUL8_SIGNED_EN to honour req_signed_i. The unsigned-only
// build leaves out the magnitude conversion, the negation and the signed overflow rule.
module mul8_issue_ctrl #(
    parameter int unsigned MUL_LAT = 1  // legal range 1..4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_a_i,
    input  logic [7:0]  req_b_i,
    input  logic        req_signed_i,
    output logic [7:0]  mul_a_o,
    output logic [7:0]  mul_b_o,
    input  logic [15:0] mul_result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_product_o,
    output logic        rsp_ovf8_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [1:0] CntLoad = 2'(MUL_LAT - 1);

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic [7:0]  mul_a_q, mul_b_q;
    logic [15:0] rsp_product_q;
    logic        rsp_ovf8_q;
    // Cleared by reset so req_ready_o stays low until the first clock after release.
    logic        alive_q;

    logic [7:0]  op_a, op_b;
    logic [15:0] prod_fix;
    logic        ovf_fix;
    logic        accept;

`ifdef MUL8_SIGNED_EN
    logic        neg_q, sgn_q;
    logic        op_neg, op_sgn;
`else
    logic        unused_req_signed;
    assign unused_req_signed = req_signed_i;
`endif

    // Handshake and status outputs decode directly from the state register.
    assign req_ready_o   = (state_q == StIdle && alive_q) || (state_q == StDone && rsp_ready_i);
    assign accept        = req_valid_i && req_ready_o;
    assign rsp_valid_o   = (state_q == StDone);
    assign busy_o        = (state_q != StIdle);
    assign mul_a_o       = mul_a_q;
    assign mul_b_o       = mul_b_q;
    assign rsp_product_o = rsp_product_q;
    assign rsp_ovf8_o    = rsp_ovf8_q;

    // Operand conditioning: signed requests feed magnitudes to the unsigned array.
    always_comb begin
        op_a = req_a_i;
        op_b = req_b_i;
`ifdef MUL8_SIGNED_EN
        op_sgn = req_signed_i;
        op_neg = req_signed_i && (req_a_i[7] ^ req_b_i[7]);
        if (req_signed_i && req_a_i[7]) op_a = -req_a_i;  // -128 wraps to 8'h80
        if (req_signed_i && req_b_i[7]) op_b = -req_b_i;
`endif
    end

    // Product fix-up: restore the sign and classify whether it fits in 8 bits.
    always_comb begin
        prod_fix = mul_result_i;
        ovf_fix  = |prod_fix[15:8];
`ifdef MUL8_SIGNED_EN
        if (neg_q) prod_fix = -mul_result_i;
        if (sgn_q) ovf_fix = !((&prod_fix[15:7]) || !(|prod_fix[15:7]));
`endif
    end

    // Control FSM with all datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            rsp_product_q <= '0;
            rsp_ovf8_q    <= 1'b0;
            alive_q       <= 1'b0;
`ifdef MUL8_SIGNED_EN
            neg_q         <= 1'b0;
            sgn_q         <= 1'b0;
`endif
        end else begin
            alive_q <= 1'b1;
            if (accept) begin
                mul_a_q <= op_a;
                mul_b_q <= op_b;
                cnt_q   <= CntLoad;
`ifdef MUL8_SIGNED_EN
                neg_q   <= op_neg;
                sgn_q   <= op_sgn;
`endif
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) state_q <= StCalc;
                end
                StCalc: begin
                    if (cnt_q == 2'd0) begin
                        rsp_product_q <= prod_fix;
                        rsp_ovf8_q    <= ovf_fix;
                        state_q       <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StDone: begin
                    if (rsp_ready_i) state_q <= req_valid_i ? StCalc : StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
